p2s_sched: RTL
==============

// Module: p2s_sched
// PURPOSE
//  Round-robin scheduler sharing one parallel-to-serial shifter (P2S) among NREQ requesters,
//  e.g. 7-segment and LED frame sources. Grants one requester, latches its word onto the P2S
//  parallel input, generates the start pulse, times the shift, then acks the requester.
//  Sits between the display sources and the P2S instance; one transfer is in flight at a time.
// PARAMETERS
//  DATA_BITS    16  width of each requester word and of p2s_pdata
//  NREQ         2   number of requesters (>=2)
//  ID_BITS      1   width of grant_id; must satisfy 2**ID_BITS >= NREQ
//  START_CYCLES 2   cycles p2s_start is held high (>=2 so the P2S 2-stage edge detect sees it)
//  GUARD        2   extra cycles added to DATA_BITS for the shift window
// PORTS
//  clk        in   1               system clock, all logic on posedge
//  rstn       in   1               synchronous active-low reset
//  req        in   NREQ            level request per requester, held until its ack
//  data       in   NREQ*DATA_BITS  word i = data[i*DATA_BITS +: DATA_BITS]
//  ack        out  NREQ            one-cycle pulse: transfer for requester i done
//  busy       out  1               high from grant cycle through ack cycle inclusive
//  grant_id   out  ID_BITS         index of requester being served (valid while busy)
//  p2s_start  out  1               start to P2S
//  p2s_pdata  out  DATA_BITS       parallel word to P2S, stable for whole transfer
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): state=IDLE, ack=0, busy=0, grant_id=0, p2s_start=0,
//    p2s_pdata=0, cycle counter=0, round-robin pointer rr=0 (requester 0 highest priority).
//    Reset at any point aborts the transfer: no ack is issued for it.
//  - All outputs registered. FSM: IDLE -> START -> SHIFT -> DONE -> IDLE.
//  - IDLE: if any req bit set, pick first set bit scanning rr, rr+1, ... mod NREQ;
//    latch grant_id and p2s_pdata <= word[grant]; busy<=1; counter<=0; go START.
//    No req: stay IDLE, outputs unchanged except busy=0.
//  - START: p2s_start=1 for exactly START_CYCLES cycles, then SHIFT.
//  - SHIFT: p2s_start=0 for DATA_BITS+GUARD cycles, then DONE.
//  - DONE: ack[grant_id]=1 for one cycle, busy still 1; rr <= (grant_id+1) mod NREQ; go IDLE.
//  - IDLE always lasts >=1 cycle after DONE, so p2s_start is low >= DATA_BITS+GUARD+1 cycles
//    between pulses.
//  - Latency: req sampled in IDLE at cycle 0 -> p2s_start high cycles 1..START_CYCLES ->
//    ack in cycle 1+START_CYCLES+DATA_BITS+GUARD (21 with defaults). Back-to-back period 22.
//  - data changes after the grant cycle are ignored; p2s_pdata and grant_id hold until the next
//    grant (not cleared at DONE).
//  - req dropped mid-transfer: transfer completes and ack still pulses; no re-grant unless
//    req is high again in IDLE. req held through ack cycle is re-arbitrated in IDLE (fair by rr).
//  - Simultaneous requests: rr guarantees alternation; no requester waits more than NREQ-1
//    transfers. Out-of-range grant ids never generated.
// TESTING
//  1. rstn=0 two cycles with req=2'b11 -> ack=0,busy=0,p2s_start=0,p2s_pdata=0,grant_id=0.
//  2. req=01, data0=16'hA5C3 at cycle 0 -> p2s_pdata=A5C3 from cycle 1, p2s_start=1 cycles
//     1-2 only, busy cycles 1-21, ack=01 only in cycle 21.
//  3. req=11 held, data0=1111, data1=2222 -> grants 0,1,0,1; ack 01 @21, 10 @43, 01 @65.
//  4. req=01 with data0=A5C3, data0->0000 at cycle 5 -> p2s_pdata stays A5C3 to cycle 21.
//  5. req=01 asserted cycle 0, dropped cycle 6 -> ack=01 still @21, then IDLE, busy=0.
//  6. req=01, rstn=0 at cycle 10 -> all outputs 0 next cycle, no ack; release with req=10 ->
//     grant_id=1, ack=10 21 cycles after the first IDLE sample.

Source files
------------

// File: rtl/p2s_sched.sv
// p2s_sched: round-robin scheduler that shares one parallel-to-serial shifter
// among NREQ requesters. A granted word is latched onto p2s_pdata. p2s_start
// then pulses for START_CYCLES cycles, and the shift window runs for
// DATA_BITS+GUARD cycles. The served requester gets a one-cycle ack, and the
// round-robin pointer moves past it. Only one transfer is in flight at a time.
module p2s_sched #(
  parameter int DATA_BITS    = 16,
  parameter int NREQ         = 2,
  parameter int ID_BITS      = 1,
  parameter int START_CYCLES = 2,
  parameter int GUARD        = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATA_BITS-1:0] data,
  output logic [NREQ-1:0]           ack,
  output logic                      busy,
  output logic [ID_BITS-1:0]        grant_id,
  output logic                      p2s_start,
  output logic [DATA_BITS-1:0]      p2s_pdata
);

  // Shift window length and the counter that times both START and SHIFT.
  localparam int SHIFT_CYCLES = DATA_BITS + GUARD;
  localparam int CNT_MAX      = (START_CYCLES > SHIFT_CYCLES) ? START_CYCLES : SHIFT_CYCLES;
  localparam int CNT_BITS     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_BITS-1:0] START_LAST = CNT_BITS'(START_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] SHIFT_LAST = CNT_BITS'(SHIFT_CYCLES - 1);
  localparam logic [ID_BITS-1:0]  LAST_ID    = ID_BITS'(NREQ - 1);
  localparam logic [NREQ-1:0]     ONE_HOT0   = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [CNT_BITS-1:0]   r_cnt;
  logic [CNT_BITS-1:0]   w_cnt_nxt;
  logic [ID_BITS-1:0]    r_rr;
  logic [ID_BITS-1:0]    w_rr_nxt;

  logic [NREQ-1:0]       r_ack;
  logic [NREQ-1:0]       w_ack_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic [ID_BITS-1:0]    r_grant_id;
  logic [ID_BITS-1:0]    w_grant_id_nxt;
  logic                  r_start;
  logic                  w_start_nxt;
  logic [DATA_BITS-1:0]  r_pdata;
  logic [DATA_BITS-1:0]  w_pdata_nxt;

  // Arbiter results.
  logic                  w_any_req;
  logic [ID_BITS-1:0]    w_pick;
  logic [DATA_BITS-1:0]  w_pick_word;

  // Rotating-priority pick: first set req bit scanning rr, rr+1, ... mod NREQ.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    idx       = 0;
    w_any_req = 1'b0;
    w_pick    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_any_req && req[idx]) begin
        w_any_req = 1'b1;
        w_pick    = ID_BITS'(idx);
      end
    end
  end

  // Word of the winning requester, latched only in the grant cycle.
  assign w_pick_word = data[int'(w_pick)*DATA_BITS +: DATA_BITS];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous: rstn is only looked at on the rising clock edge.
    if (!rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> START -> SHIFT -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req)           w_state_nxt = S_START;
      S_START: if (r_cnt == START_LAST) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == SHIFT_LAST) w_state_nxt = S_DONE;
      S_DONE:                           w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, counter and rr pointer.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_rr_nxt       = r_rr;
    w_ack_nxt      = '0;
    w_busy_nxt     = r_busy;
    w_grant_id_nxt = r_grant_id;
    w_start_nxt    = r_start;
    w_pdata_nxt    = r_pdata;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (w_any_req) begin
          w_grant_id_nxt = w_pick;
          w_pdata_nxt    = w_pick_word;
          w_busy_nxt     = 1'b1;
          w_start_nxt    = 1'b1;
          w_cnt_nxt      = '0;
        end
      end
      S_START: begin
        if (r_cnt == START_LAST) begin
          w_start_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_BITS'(1);
        end
      end
      S_SHIFT: begin
        if (r_cnt == SHIFT_LAST) begin
          w_ack_nxt = ONE_HOT0 << r_grant_id;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_BITS'(1);
        end
      end
      S_DONE: begin
        // busy drops after the ack cycle; grant_id and pdata hold until the next grant.
        w_busy_nxt = 1'b0;
        w_cnt_nxt  = '0;
        w_rr_nxt   = (r_grant_id == LAST_ID) ? '0 : r_grant_id + ID_BITS'(1);
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_start_nxt = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output, counter and pointer registers; reset aborts any transfer without an ack.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_rr       <= '0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_grant_id <= '0;
      r_start    <= 1'b0;
      r_pdata    <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_rr       <= w_rr_nxt;
      r_ack      <= w_ack_nxt;
      r_busy     <= w_busy_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_start    <= w_start_nxt;
      r_pdata    <= w_pdata_nxt;
    end
  end

  assign ack       = r_ack;
  assign busy      = r_busy;
  assign grant_id  = r_grant_id;
  assign p2s_start = r_start;
  assign p2s_pdata = r_pdata;

endmodule
